// File: rtl/scale_pkg.sv
// Shared timebase-selector types, index limits and saturating step helper.
// Imported by scale_selector and by the downstream time/div lookup stage.
package scale_pkg;

    localparam int SCALE_W = 4;

    localparam logic [SCALE_W-1:0] SCALE_MIN     = 4'd0;
    localparam logic [SCALE_W-1:0] SCALE_MAX     = 4'd12;
    localparam logic [SCALE_W-1:0] SCALE_DEFAULT = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } sel_state_t;

    typedef enum logic {
        UP,
        DN
    } dir_t;

    // Saturating +/-1 on the scale index; never leaves MIN..MAX.
    function automatic logic [SCALE_W-1:0] scale_step(
        input logic [SCALE_W-1:0] cur,
        input logic               up,
        input logic               dn
    );
        if (up && cur != SCALE_MAX) begin
            return cur + 1'b1;
        end
        if (dn && cur != SCALE_MIN) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one pushbutton.
// Ports: clk, rst (sync, active-high), raw (async button), level (debounced).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/scale_selector.sv
// Up/down pushbutton timebase selector with auto-repeat and saturation.
// Ports: clk, rst, btn_up, btn_down -> scale_out, scale_changed, at_min, at_max.
module scale_selector
    import scale_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000,
    parameter int DEFAULT_SCALE   = int'(SCALE_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [SCALE_W-1:0] scale_out,
    output logic               scale_changed,
    output logic               at_min,
    output logic               at_max
);

    localparam int TIMER_MAX =
        (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TIMER_W =
        (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] HOLD_LAST =
        TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST =
        TIMER_W'(REPEAT_CYCLES - 1);
    localparam logic [SCALE_W-1:0] RST_SCALE =
        SCALE_W'(DEFAULT_SCALE);

    logic up_db;
    logic dn_db;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_up (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_up),
        .level(up_db)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_dn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_down),
        .level(dn_db)
    );

    sel_state_t         state;
    sel_state_t         state_n;
    dir_t               dir;
    dir_t               dir_n;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_n;
    logic [TIMER_W-1:0] term;
    logic               mine;
    logic               other;
    logic               step_up;
    logic               step_dn;
    logic [SCALE_W-1:0] scale_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir   <= UP;
            timer <= '0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            timer <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        timer_n = timer;
        step_up = 1'b0;
        step_dn = 1'b0;
        mine    = (dir == UP) ? up_db : dn_db;
        other   = (dir == UP) ? dn_db : up_db;
        term    = (state == REPEAT) ? REPEAT_LAST : HOLD_LAST;

        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    (up_db & ~dn_db): begin
                        step_up = 1'b1;
                        dir_n   = UP;
                        timer_n = '0;
                        state_n = HOLD;
                    end
                    (dn_db & ~up_db): begin
                        step_dn = 1'b1;
                        dir_n   = DN;
                        timer_n = '0;
                        state_n = HOLD;
                    end
                    (up_db & dn_db): begin
                        state_n = LOCK;
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
            HOLD, REPEAT: begin
                // Clearing the timer on every exit keeps it from wrapping.
                if (other) begin
                    state_n = LOCK;
                    timer_n = '0;
                end else if (!mine) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer == term) begin
                    step_up = (dir == UP);
                    step_dn = (dir == DN);
                    timer_n = '0;
                    state_n = REPEAT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            LOCK: begin
                if (!up_db && !dn_db) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign scale_next = scale_step(scale_out, step_up, step_dn);

    always_ff @(posedge clk) begin
        if (rst) begin
            scale_out     <= RST_SCALE;
            scale_changed <= 1'b0;
            at_min        <= 1'b0;
            at_max        <= 1'b0;
        end else begin
            scale_out     <= scale_next;
            scale_changed <= (scale_next != scale_out);
            at_min        <= (scale_next == SCALE_MIN);
            at_max        <= (scale_next == SCALE_MAX);
        end
    end

endmodule

// File: tb/tb_scale_selector.sv
// Randomised bench for scale_selector against a window-based behavioural model.
// Drives inputs on falling edges, compares all outputs every falling edge.
module tb_scale_selector;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
    localparam int DEF  = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] scale_out;
    logic       scale_changed;
    logic       at_min;
    logic       at_max;

    int checks = 0;
    int errors = 0;

    scale_selector #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .DEFAULT_SCALE  (DEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .scale_out    (scale_out),
        .scale_changed(scale_changed),
        .at_min       (at_min),
        .at_max       (at_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Model: raw samples per clock edge, newest first. A debounced level
    // flips when the DB samples taken 2..DB+1 edges ago all disagree with it.
    bit hu[$];
    bit hd[$];
    bit lu, ld;
    int mode;      // 0 idle, 1 pressed, 2 locked
    bit mdir;      // 0 up, 1 down
    int age;       // edges since first step of current press
    int m_sc;
    bit m_chg, m_min, m_max;

    task automatic model_step(input bit r, input bit u, input bit d);
        bit su, sd, mine, other, fu, fd;
        int old;
        if (r) begin
            hu.delete();
            hd.delete();
            for (int i = 0; i < DB + 2; i++) begin
                hu.push_back(1'b0);
                hd.push_back(1'b0);
            end
            lu = 0; ld = 0; mode = 0; mdir = 0; age = 0;
            m_sc = DEF; m_chg = 0; m_min = 0; m_max = 0;
            return;
        end
        su = 0;
        sd = 0;
        if (mode == 0) begin
            if (lu && !ld) begin
                su = 1; mode = 1; mdir = 0; age = 0;
            end else if (ld && !lu) begin
                sd = 1; mode = 1; mdir = 1; age = 0;
            end else if (lu && ld) begin
                mode = 2;
            end
        end else if (mode == 1) begin
            mine  = mdir ? ld : lu;
            other = mdir ? lu : ld;
            if (other) mode = 2;
            else if (!mine) mode = 0;
            else begin
                age++;
                if (age == HOLD || (age > HOLD && (age - HOLD) % REP == 0)) begin
                    if (mdir) sd = 1;
                    else su = 1;
                end
            end
        end else begin
            if (!lu && !ld) mode = 0;
        end
        old = m_sc;
        if (su && m_sc < 12) m_sc++;
        if (sd && m_sc > 0) m_sc--;
        m_chg = (m_sc != old);
        m_min = (m_sc == 0);
        m_max = (m_sc == 12);

        hu.push_front(u);
        void'(hu.pop_back());
        hd.push_front(d);
        void'(hd.pop_back());
        fu = 1;
        fd = 1;
        for (int i = 2; i < DB + 2; i++) begin
            if (hu[i] == lu) fu = 0;
            if (hd[i] == ld) fd = 0;
        end
        if (fu) lu = !lu;
        if (fd) ld = !ld;
    endtask

    initial begin
        bit r, u, d;
        forever begin
            @(posedge clk);
            r = rst;
            u = btn_up;
            d = btn_down;
            @(negedge clk);
            model_step(r, u, d);
            check("scale_out", 32'(scale_out), 32'(m_sc));
            check("scale_changed", 32'(scale_changed), 32'(m_chg));
            check("at_min", 32'(at_min), 32'(m_min));
            check("at_max", 32'(at_max), 32'(m_max));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int len;
        cyc(3);
        rst = 1'b0;

        // Idle after reset.
        cyc(100);
        check("rst_scale", 32'(scale_out), 9);
        check("rst_chg", 32'(scale_changed), 0);
        check("rst_min", 32'(at_min), 0);
        check("rst_max", 32'(at_max), 0);

        // Short glitch ignored, then a clean press.
        btn_up = 1'b1;
        cyc(3);
        btn_up = 1'b0;
        cyc(10);
        check("glitch", 32'(scale_out), 9);
        btn_up = 1'b1;
        cyc(6);
        check("press_early", 32'(scale_out), 9);
        cyc(1);
        check("press_step", 32'(scale_out), 10);
        check("press_pulse", 32'(scale_changed), 1);
        cyc(3);
        btn_up = 1'b0;
        cyc(20);
        check("press_single", 32'(scale_out), 10);

        // Auto-repeat into the top.
        do_reset();
        pulses = 0;
        btn_up = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (scale_changed) pulses++;
        end
        check("rep_top", 32'(scale_out), 12);
        check("rep_max", 32'(at_max), 1);
        check("rep_pulses", 32'(pulses), 3);
        btn_up = 1'b0;
        cyc(20);

        // Auto-repeat down into the bottom.
        do_reset();
        pulses = 0;
        btn_down = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (scale_changed) pulses++;
        end
        check("dn_bottom", 32'(scale_out), 0);
        check("dn_min", 32'(at_min), 1);
        check("dn_pulses", 32'(pulses), 9);
        btn_down = 1'b0;
        cyc(20);

        // Both buttons lock out stepping.
        do_reset();
        btn_up = 1'b1;
        cyc(10);
        btn_down = 1'b1;
        cyc(40);
        check("lock_frozen", 32'(scale_out), 10);
        btn_down = 1'b0;
        cyc(40);
        check("lock_up_only", 32'(scale_out), 10);
        btn_up = 1'b0;
        cyc(20);
        btn_down = 1'b1;
        cyc(10);
        btn_down = 1'b0;
        cyc(20);
        check("lock_exit_dn", 32'(scale_out), 9);

        // Reset in the middle of a repeat.
        do_reset();
        btn_up = 1'b1;
        cyc(30);
        check("mid_before", 32'(scale_out), 11);
        rst = 1'b1;
        cyc(1);
        check("mid_reset", 32'(scale_out), 9);
        rst = 1'b0;
        cyc(6);
        check("mid_wait", 32'(scale_out), 9);
        cyc(1);
        check("mid_repress", 32'(scale_out), 10);
        btn_up = 1'b0;
        cyc(20);

        // Random button activity with occasional resets.
        for (int k = 0; k < 200; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            btn_up   = (sel < 4) || (sel == 8);
            btn_down = (sel >= 4 && sel < 7) || (sel == 8);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 5);
            else len = $urandom_range(1, 100);
            for (int i = 0; i < len; i++) begin
                rst = ($urandom_range(0, 400) == 0);
                cyc(1);
            end
            rst = 1'b0;
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        cyc(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
